// File: rtl/vga_time_source_sync.sv
// vga_time_source_sync
// Picks the clock/date and timer fields shown by the VGA text generator.
// Each group comes either from the user edit inputs or from an atomic
// snapshot of the RTC read engine. After an edit, the edited group keeps
// showing the user value until enough fresh RTC reads arrive, or until a
// timeout expires. The field under the edit cursor blinks.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   en_escr    write/edit in progress
//   en_clock   1 = editing clock group, 0 = editing timer group
//   usu_clk    user clock fields, field i at [i*W +: W]
//   usu_tmr    user timer fields
//   rtc_valid  one-cycle strobe, rtc_clk/rtc_tmr form a consistent read
//   rtc_clk    RTC clock fields
//   rtc_tmr    RTC timer fields
//   cursor     edited field index (0..N_CLK-1 clock, N_CLK.. timer)
//   vga_clk    displayed clock fields (registered)
//   vga_tmr    displayed timer fields (registered)
//   vga_blank  per-field blank mask, indexed like cursor (registered)
//   vga_state  0 LIVE, 1 EDIT_CLK, 2 EDIT_TMR, 3 SETTLE (registered)
module vga_time_source_sync #(
    parameter int W            = 8,
    parameter int N_CLK        = 6,
    parameter int N_TMR        = 3,
    parameter int SETTLE_READS = 2,
    parameter int SETTLE_MAX   = 1024,
    parameter int BLINK_HALF   = 25_000_000,
    parameter int CW           = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en_escr,
    input  logic                   en_clock,
    input  logic [N_CLK*W-1:0]     usu_clk,
    input  logic [N_TMR*W-1:0]     usu_tmr,
    input  logic                   rtc_valid,
    input  logic [N_CLK*W-1:0]     rtc_clk,
    input  logic [N_TMR*W-1:0]     rtc_tmr,
    input  logic [CW-1:0]          cursor,
    output logic [N_CLK*W-1:0]     vga_clk,
    output logic [N_TMR*W-1:0]     vga_tmr,
    output logic [N_CLK+N_TMR-1:0] vga_blank,
    output logic [1:0]             vga_state
);

    localparam int N_TOT = N_CLK + N_TMR;
    localparam int RW    = (SETTLE_READS > 1) ? $clog2(SETTLE_READS + 1) : 1;
    localparam int YW    = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
    localparam int BW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [RW-1:0] RD_LAST    = RW'(SETTLE_READS - 1);
    localparam logic [YW-1:0] CYC_LAST   = YW'(SETTLE_MAX - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    localparam logic [1:0] ST_LIVE     = 2'd0;
    localparam logic [1:0] ST_EDIT_CLK = 2'd1;
    localparam logic [1:0] ST_EDIT_TMR = 2'd2;
    localparam logic [1:0] ST_SETTLE   = 2'd3;

    logic [1:0]         state_r;
    logic [N_CLK*W-1:0] sh_clk_r;
    logic [N_TMR*W-1:0] sh_tmr_r;
    logic [N_CLK*W-1:0] vga_clk_r;
    logic [N_TMR*W-1:0] vga_tmr_r;
    logic [N_TOT-1:0]   vga_blank_r;
    logic [RW-1:0]      rd_cnt_r;
    logic [YW-1:0]      cyc_cnt_r;
    logic [BW-1:0]      blink_cnt_r;
    logic               phase_r;
    logic               edited_clk_r;

    logic [1:0]         state_nx_s;
    logic               settle_done_s;
    logic               edit_nx_s;
    logic               hold_s;
    logic               edited_clk_nx_s;
    logic [N_CLK*W-1:0] clk_nx_s;
    logic [N_TMR*W-1:0] tmr_nx_s;
    logic [N_TOT-1:0]   blank_nx_s;
    logic [RW-1:0]      rd_cnt_nx_s;
    logic [YW-1:0]      cyc_cnt_nx_s;
    logic [BW-1:0]      blink_cnt_nx_s;
    logic               phase_nx_s;

    // SETTLE ends on the strobe that completes the required read count, or on timeout
    assign settle_done_s = (rtc_valid && (rd_cnt_r == RD_LAST)) || (cyc_cnt_r == CYC_LAST);
    assign edit_nx_s     = (state_nx_s == ST_EDIT_CLK) || (state_nx_s == ST_EDIT_TMR);
    // The edited group keeps its last value in SETTLE and on the edge leaving it,
    // so the user value stays visible for one LIVE cycle before the new read shows
    assign hold_s        = (state_nx_s == ST_SETTLE) || (state_r == ST_SETTLE);

    // Next-state decision; an active edit request overrides everything else
    always_comb begin
        state_nx_s = state_r;
        if (en_escr && en_clock) begin
            state_nx_s = ST_EDIT_CLK;
        end else if (en_escr) begin
            state_nx_s = ST_EDIT_TMR;
        end else begin
            case (state_r)
                ST_EDIT_CLK: state_nx_s = ST_SETTLE;
                ST_EDIT_TMR: state_nx_s = ST_SETTLE;
                ST_SETTLE: begin
                    if (settle_done_s) begin
                        state_nx_s = ST_LIVE;
                    end else begin
                        state_nx_s = ST_SETTLE;
                    end
                end
                ST_LIVE:     state_nx_s = ST_LIVE;
                default:     state_nx_s = ST_LIVE;
            endcase
        end
    end

    // Track which group was being edited so SETTLE knows which one to hold
    always_comb begin
        edited_clk_nx_s = edited_clk_r;
        if (state_r == ST_EDIT_CLK) begin
            edited_clk_nx_s = 1'b1;
        end else if (state_r == ST_EDIT_TMR) begin
            edited_clk_nx_s = 1'b0;
        end else begin
            edited_clk_nx_s = edited_clk_r;
        end
    end

    // Source selection follows the next state so data and vga_state change together
    always_comb begin
        clk_nx_s = sh_clk_r;
        tmr_nx_s = sh_tmr_r;
        case (state_nx_s)
            ST_EDIT_CLK: begin
                clk_nx_s = usu_clk;
                tmr_nx_s = sh_tmr_r;
            end
            ST_EDIT_TMR: begin
                clk_nx_s = sh_clk_r;
                tmr_nx_s = usu_tmr;
            end
            default: begin
                if (hold_s && edited_clk_nx_s) begin
                    clk_nx_s = vga_clk_r;
                    tmr_nx_s = sh_tmr_r;
                end else if (hold_s) begin
                    clk_nx_s = sh_clk_r;
                    tmr_nx_s = vga_tmr_r;
                end else begin
                    clk_nx_s = sh_clk_r;
                    tmr_nx_s = sh_tmr_r;
                end
            end
        endcase
    end

    // Read and cycle counters run only while staying in SETTLE; zero on entry
    always_comb begin
        rd_cnt_nx_s  = '0;
        cyc_cnt_nx_s = '0;
        if ((state_r == ST_SETTLE) && (state_nx_s == ST_SETTLE)) begin
            rd_cnt_nx_s  = rd_cnt_r + RW'(rtc_valid);
            cyc_cnt_nx_s = cyc_cnt_r + YW'(1);
        end else begin
            rd_cnt_nx_s  = '0;
            cyc_cnt_nx_s = '0;
        end
    end

    // Blink phase restarts visible on every entry into an edit state
    always_comb begin
        blink_cnt_nx_s = '0;
        phase_nx_s     = 1'b0;
        if (edit_nx_s && (state_nx_s == state_r)) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_nx_s = '0;
                phase_nx_s     = ~phase_r;
            end else begin
                blink_cnt_nx_s = blink_cnt_r + BW'(1);
                phase_nx_s     = phase_r;
            end
        end else begin
            blink_cnt_nx_s = '0;
            phase_nx_s     = 1'b0;
        end
    end

    // Blank only the addressed field, and only while editing; out-of-range cursor blanks nothing
    always_comb begin
        blank_nx_s = '0;
        if (edit_nx_s) begin
            for (int i = 0; i < N_TOT; i++) begin
                blank_nx_s[i] = phase_nx_s && (32'(cursor) == i);
            end
        end else begin
            blank_nx_s = '0;
        end
    end

    // All state, shadow and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_LIVE;
            sh_clk_r     <= '0;
            sh_tmr_r     <= '0;
            vga_clk_r    <= '0;
            vga_tmr_r    <= '0;
            vga_blank_r  <= '0;
            rd_cnt_r     <= '0;
            cyc_cnt_r    <= '0;
            blink_cnt_r  <= '0;
            phase_r      <= 1'b0;
            edited_clk_r <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            vga_clk_r    <= clk_nx_s;
            vga_tmr_r    <= tmr_nx_s;
            vga_blank_r  <= blank_nx_s;
            rd_cnt_r     <= rd_cnt_nx_s;
            cyc_cnt_r    <= cyc_cnt_nx_s;
            blink_cnt_r  <= blink_cnt_nx_s;
            phase_r      <= phase_nx_s;
            edited_clk_r <= edited_clk_nx_s;
            // Whole snapshot or nothing: both groups load on the same strobe
            if (rtc_valid) begin
                sh_clk_r <= rtc_clk;
                sh_tmr_r <= rtc_tmr;
            end
        end
    end

    assign vga_clk   = vga_clk_r;
    assign vga_tmr   = vga_tmr_r;
    assign vga_blank = vga_blank_r;
    assign vga_state = state_r;

endmodule

// File: tb/tb_vga_time_source_sync.sv
module tb_vga_time_source_sync;

    localparam logic [3:0] M_CLK = 4'b1000;
    localparam logic [3:0] M_TMR = 4'b0100;
    localparam logic [3:0] M_BLK = 4'b0010;
    localparam logic [3:0] M_ST  = 4'b0001;
    localparam logic [3:0] M_ALL = 4'b1111;

    logic        clk;
    logic        rst;
    logic        en_escr;
    logic        en_clock;
    logic [47:0] usu_clk;
    logic [23:0] usu_tmr;
    logic        rtc_valid;
    logic [47:0] rtc_clk;
    logic [23:0] rtc_tmr;
    logic [3:0]  cursor;
    logic [47:0] vga_clk;
    logic [23:0] vga_tmr;
    logic [8:0]  vga_blank;
    logic [1:0]  vga_state;

    typedef struct {
        int          cyc;
        logic [3:0]  mask;
        logic [47:0] clk;
        logic [23:0] tmr;
        logic [8:0]  blank;
        logic [1:0]  state;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    vga_time_source_sync #(
        .W(8), .N_CLK(6), .N_TMR(3), .SETTLE_READS(2),
        .SETTLE_MAX(8), .BLINK_HALF(4), .CW(4)
    ) dut (
        .clk(clk), .reset(rst), .en_escr(en_escr), .en_clock(en_clock),
        .usu_clk(usu_clk), .usu_tmr(usu_tmr), .rtc_valid(rtc_valid),
        .rtc_clk(rtc_clk), .rtc_tmr(rtc_tmr), .cursor(cursor),
        .vga_clk(vga_clk), .vga_tmr(vga_tmr), .vga_blank(vga_blank),
        .vga_state(vga_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input string fld, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s @cyc %0d: got %h expected %h", tag, fld, cyc, act, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge; every queued expectation
    // due at this cycle is popped and compared
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", mon_e.tag, mon_e.cyc, cyc);
            end else begin
                if (mon_e.mask[3]) cmp(mon_e.tag, "vga_clk",   64'(vga_clk),   64'(mon_e.clk));
                if (mon_e.mask[2]) cmp(mon_e.tag, "vga_tmr",   64'(vga_tmr),   64'(mon_e.tmr));
                if (mon_e.mask[1]) cmp(mon_e.tag, "vga_blank", 64'(vga_blank), 64'(mon_e.blank));
                if (mon_e.mask[0]) cmp(mon_e.tag, "vga_state", 64'(vga_state), 64'(mon_e.state));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Queue an expectation dc cycles ahead, kept sorted by due cycle
    task automatic exp_at(input int dc, input logic [3:0] m, input logic [47:0] c,
                          input logic [23:0] t, input logic [8:0] b, input logic [1:0] s,
                          input string tag);
        exp_t e;
        int   idx;
        e.cyc = cyc + dc; e.mask = m; e.clk = c; e.tmr = t;
        e.blank = b; e.state = s; e.tag = tag;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > e.cyc) idx--;
        sb.insert(idx, e);
    endtask

    initial begin
        rst = 1'b1; en_escr = 1'b0; en_clock = 1'b0;
        usu_clk = 48'h0; usu_tmr = 24'h0; rtc_valid = 1'b0;
        rtc_clk = 48'h0; rtc_tmr = 24'h0; cursor = 4'd0;

        // Reset: a strobe while reset is held must be ignored
        tick(); tick();
        rtc_valid = 1'b1; rtc_clk = 48'h99;
        exp_at(0, M_ALL, 48'h0, 24'h0, 9'h0, 2'd0, "reset0");
        exp_at(1, M_ALL, 48'h0, 24'h0, 9'h0, 2'd0, "reset1");
        tick();
        rst = 1'b0; rtc_valid = 1'b0;
        tick();
        // LIVE: rtc strobe reaches the display two cycles later
        rtc_valid = 1'b1; rtc_clk = 48'h45;
        exp_at(1, M_ALL, 48'h0,  24'h0, 9'h0, 2'd0, "live_lat1");
        exp_at(2, M_ALL, 48'h45, 24'h0, 9'h0, 2'd0, "live_lat2");
        tick();
        rtc_valid = 1'b0;
        tick();

        // EDIT_CLK: user min after 1 cycle, shadowed timer after 2
        en_escr = 1'b1; en_clock = 1'b1; usu_clk = 48'h3000;
        rtc_valid = 1'b1; rtc_tmr = 24'h12;
        exp_at(1, M_ALL, 48'h3000, 24'h0,  9'h0, 2'd1, "edit_clk1");
        exp_at(2, M_ALL, 48'h3000, 24'h12, 9'h0, 2'd1, "edit_clk2");
        tick();
        rtc_valid = 1'b0;
        tick();

        // EDIT_TMR blink on cursor 7, then cursor 12 while phase is high
        en_clock = 1'b0; cursor = 4'd7; usu_tmr = 24'h050000;
        for (int o = 1; o <= 16; o++) begin
            exp_at(o, M_ALL, 48'h45, 24'h050000,
                   ((o >= 5) && (o <= 8)) ? 9'h080 : 9'h000, 2'd2, "blink");
        end
        for (int k = 0; k < 12; k++) tick();
        cursor = 4'd12;
        for (int k = 0; k < 4; k++) tick();

        // Timer edit -> SETTLE; transition-edge strobe not counted,
        // display held at user value until the second counted strobe
        en_escr = 1'b0; rtc_valid = 1'b1; rtc_tmr = 24'h090000;
        for (int o = 1; o <= 3; o++)
            exp_at(o, M_ALL, 48'h45, 24'h050000, 9'h0, 2'd3, "settle_hold");
        for (int o = 4; o <= 6; o++)
            exp_at(o, M_ALL, 48'h45, 24'h050000, 9'h0, 2'd0, "settle_exit");
        tick();
        tick();
        rtc_valid = 1'b0;
        tick();
        rtc_valid = 1'b1; rtc_tmr = 24'h050000;
        tick();
        rtc_valid = 1'b0;
        tick(); tick();

        // Clock edit, then SETTLE timeout: exactly 8 cycles
        en_escr = 1'b1; en_clock = 1'b1; usu_clk = 48'h77;
        exp_at(1, M_ALL, 48'h77, 24'h050000, 9'h0, 2'd1, "to_edit");
        for (int o = 2; o <= 9; o++)
            exp_at(o, M_ALL, 48'h77, 24'h050000, 9'h0, 2'd3, "to_settle");
        exp_at(10, M_ALL, 48'h77, 24'h050000, 9'h0, 2'd0, "to_live_hold");
        exp_at(11, M_ALL, 48'h45, 24'h050000, 9'h0, 2'd0, "to_live_new");
        tick();
        en_escr = 1'b0;
        for (int k = 0; k < 10; k++) tick();

        // Asynchronous reset while in SETTLE
        en_escr = 1'b1; en_clock = 1'b0; usu_tmr = 24'h000033;
        tick();
        en_escr = 1'b0;
        exp_at(1, M_ST, 48'h0, 24'h0, 9'h0, 2'd3, "pre_reset");
        tick();
        tick();
        rst = 1'b1;
        exp_at(0, M_ALL, 48'h0, 24'h0, 9'h0, 2'd0, "async_reset");
        tick();
        rst = 1'b0;
        exp_at(2, M_ALL, 48'h0, 24'h0, 9'h0, 2'd0, "post_reset");
        tick(); tick();

        // Reassert en_escr in SETTLE: counters must restart
        en_escr = 1'b1; en_clock = 1'b0; usu_tmr = 24'h000033;
        exp_at(1, M_ST, 48'h0, 24'h0, 9'h0, 2'd2, "abort_e1");
        exp_at(2, M_ST, 48'h0, 24'h0, 9'h0, 2'd3, "abort_s1");
        exp_at(3, M_ST, 48'h0, 24'h0, 9'h0, 2'd3, "abort_s1b");
        exp_at(4, M_ST, 48'h0, 24'h0, 9'h0, 2'd2, "abort_e2");
        exp_at(5, M_ST, 48'h0, 24'h0, 9'h0, 2'd3, "abort_s2");
        exp_at(6, M_ST | M_TMR, 48'h0, 24'h000033, 9'h0, 2'd3, "abort_cnt_clr");
        exp_at(7, M_ST, 48'h0, 24'h0, 9'h0, 2'd3, "abort_s2b");
        exp_at(8, M_ST | M_TMR, 48'h0, 24'h000033, 9'h0, 2'd0, "abort_exit");
        exp_at(9, M_ALL, 48'h45, 24'h000011, 9'h0, 2'd0, "abort_new");
        tick();
        en_escr = 1'b0;
        tick();
        rtc_valid = 1'b1; rtc_tmr = 24'h000011;
        tick();
        rtc_valid = 1'b0; en_escr = 1'b1;
        tick();
        en_escr = 1'b0;
        tick();
        rtc_valid = 1'b1;
        tick();
        rtc_valid = 1'b0;
        tick();
        rtc_valid = 1'b1;
        tick();
        rtc_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_time_source_sync.md
# vga_time_source_sync

Parametrised, registered successor to the combinational display-source mux. It selects the time/date and timer fields sent to the VGA renderer, taking each group either from user edit inputs or from the RTC read engine. RTC data is captured only as an atomic snapshot. After a write, the user values stay on screen until fresh RTC reads confirm the write. The field under the edit cursor blinks. It sits between the edit/RTC-read modules and the VGA text generator.

## Interface
- W, 8: field width, BCD byte.
- N_CLK, 6: clock/date fields; index 0..5 = seg, min, hora, dia, mes, ano.
- N_TMR, 3: timer fields; index 0..2 = seg_T, min_T, hora_T.
- SETTLE_READS, 2: rtc_valid strobes required in SETTLE before returning to LIVE (≥1).
- SETTLE_MAX, 1024: SETTLE timeout in cycles (≥2).
- BLINK_HALF, 25_000_000: cycles per blink half-period (≥1).
- CW, 4: cursor width; must satisfy 2^CW ≥ N_CLK+N_TMR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en_escr  in  1  write/edit in progress.
- en_clock  in  1  1 = editing the clock group, 0 = editing the timer group.
- usu_clk  in  N_CLK*W  user clock fields; field i at [i*W +: W].
- usu_tmr  in  N_TMR*W  user timer fields.
- rtc_valid  in  1  one-cycle strobe: rtc_clk/rtc_tmr form a complete, consistent read.
- rtc_clk  in  N_CLK*W  RTC clock fields.
- rtc_tmr  in  N_TMR*W  RTC timer fields.
- cursor  in  CW  field under edit: 0..N_CLK-1 = clock group, N_CLK.. = timer group.
- vga_clk  out  N_CLK*W  displayed clock fields (registered).
- vga_tmr  out  N_TMR*W  displayed timer fields (registered).
- vga_blank  out  N_CLK+N_TMR  per-field blank mask, same indexing as cursor.
- vga_state  out  2  current state: 0 LIVE, 1 EDIT_CLK, 2 EDIT_TMR, 3 SETTLE.

## Operation
- Shadow registers sh_clk/sh_tmr load rtc_clk/rtc_tmr on every clock edge where rtc_valid=1, in every state. They are never partially updated.
- State transitions (priority order per cycle):
  - en_escr & en_clock → EDIT_CLK.
  - en_escr & ~en_clock → EDIT_TMR.
  - From EDIT_* with en_escr=0 → SETTLE. Record the edited group (edited_clk).
  - In SETTLE, after SETTLE_READS strobes counted, or when cyc_cnt reaches SETTLE_MAX-1 → LIVE.
  - In LIVE, stay LIVE.
- EDIT_CLK ↔ EDIT_TMR switches directly. Reasserting en_escr in SETTLE aborts settling and clears the counters.
- Output selection (registered each cycle):
  - LIVE: both groups from shadow.
  - EDIT_CLK: clock group from usu_clk, timer group from shadow.
  - EDIT_TMR: timer group from usu_tmr, clock group from shadow.
  - SETTLE: the edited group holds its last value; the other group comes from shadow.
- rd_cnt counts rtc_valid only while state=SETTLE. A strobe in the cycle that performs the EDIT→SETTLE transition does not count. rd_cnt and cyc_cnt clear on SETTLE entry.
- Blink: the phase counter restarts at 0 with phase 0 (visible) on every entry into an EDIT state. Phase toggles every BLINK_HALF cycles while in EDIT_*.
- vga_blank[cursor]=phase only in EDIT_*. All other bits are 0.
- cursor ≥ N_CLK+N_TMR gives no blanking. A cursor outside the edited group still blinks as addressed; the upstream edit module prevents this.

## Timing
- Reset, asynchronous: vga_clk=0, vga_tmr=0, vga_blank=0, vga_state=0 (LIVE), shadow=0, all counters=0, phase=0.
- User data → vga output: 1 cycle.
- rtc_valid → vga output in LIVE: 2 cycles (shadow, then output register).
- en_escr change → vga_state: 1 cycle. The output source changes in the same edge as vga_state.
- SETTLE exit on the Nth strobe: the state becomes LIVE at that edge and the shadow captures that read at the same edge. vga shows the new read one cycle later. The held user value is visible for exactly one LIVE cycle.
- Timeout: SETTLE lasts exactly SETTLE_MAX cycles if no strobes arrive.
- vga_blank updates in the same cycle as phase and state. It clears the cycle the state leaves EDIT_*.
- Reset mid-edit or mid-settle: immediate return to the reset values; the user edit is discarded.

## Test plan
- Reset with rtc_valid pulse rtc_clk[7:0]=0x45: all outputs 0 during reset. Two cycles after the strobe, vga_clk seg=0x45 and vga_state=0.
- en_escr=1, en_clock=1, usu_clk min=0x30; rtc_valid with rtc_tmr seg=0x12. Required: vga_clk min=0x30 after 1 cycle, vga_tmr seg=0x12 after 2 cycles, vga_state=1.
- BLINK_HALF=4, cursor=7, EDIT_TMR: vga_blank[7] pattern 0000 1111 0000…; all other bits 0. cursor=12 gives vga_blank all 0.
- Drop en_escr after a timer edit with hora_T=0x05 and SETTLE_READS=2. Strobe 1 with hora_T=0x09: display stays 0x05. Strobe 2 with 0x05: state=LIVE, display 0x05 throughout.
- SETTLE_MAX=8, no strobes: vga_state=3 for exactly 8 cycles, then 0. A strobe at the transition edge is not counted.
- Assert reset in SETTLE: outputs 0 and state LIVE asynchronously. Reassert en_escr in SETTLE: EDIT state next cycle and counters cleared.
